// File: rtl/inst_dec_pipe.sv
// rtl/inst_dec_pipe.sv - handshaked instruction decoder with 2-entry skid buffer
//
// Splits an instruction into opcode, register selects, extended immediate,
// write enable and illegal flag, and registers the result behind a
// valid/ready interface that never drops an instruction under back-pressure.
//
// Ports:
//   I_clk, I_rst      clock (rising edge), asynchronous active-high reset
//   I_en              stage enable; 0 freezes all state and blocks transfers
//   I_flush           synchronous discard of both buffered entries
//   I_inst, I_valid   instruction from fetch; o_ready accepts it
//   o_valid, I_ready  decoded entry to downstream
//   o_aluop, o_selA/B/D, o_imm, o_regwe, o_illegal  decoded fields
module inst_dec_pipe #(
    parameter int INST_W    = 16,
    parameter int OP_W      = 5,
    parameter int REG_W     = 3,
    parameter int SEL_W     = 4,
    parameter int IMM_SRC_W = 8,
    parameter int IMM_W     = 16,
    parameter int SIGN_EXT  = 1,
    parameter logic [(1<<(OP_W-1))-1:0] NOWB_MASK = 16'h3080,
    parameter logic [(1<<(OP_W-1))-1:0] ILL_MASK  = 16'h0000
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_en,
    input  logic              I_flush,
    input  logic [INST_W-1:0] I_inst,
    input  logic              I_valid,
    output logic              o_ready,
    output logic              o_valid,
    input  logic              I_ready,
    output logic [OP_W-1:0]   o_aluop,
    output logic [SEL_W-1:0]  o_selA,
    output logic [SEL_W-1:0]  o_selB,
    output logic [SEL_W-1:0]  o_selD,
    output logic [IMM_W-1:0]  o_imm,
    output logic              o_regwe,
    output logic              o_illegal
);

    localparam int ENT_W = OP_W + 3*SEL_W + IMM_W + 2;
    // Bits of o_imm above the source field; set together for sign extension.
    localparam logic [IMM_W-1:0] EXT_MASK = ~IMM_W'({IMM_SRC_W{1'b1}});

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                room_q;
    logic [ENT_W-1:0]    out_q, skid_q;
    logic [ENT_W-1:0]    dec_ent;
    logic                load_out, load_skid, out_from_skid;
    logic                in_x, out_x;

    // Combinational decode of the incoming instruction.
    logic [OP_W-1:0]      d_op;
    logic [SEL_W-1:0]     d_a, d_b, d_d;
    logic [IMM_SRC_W-1:0] d_src;
    logic [IMM_W-1:0]     d_imm;
    logic                 d_ill, d_we;

    always_comb begin
        d_op  = I_inst[INST_W-1 -: OP_W];
        d_a   = SEL_W'(I_inst[INST_W-OP_W-1 -: REG_W]);
        d_b   = SEL_W'(I_inst[INST_W-OP_W-REG_W-1 -: REG_W]);
        d_d   = SEL_W'(I_inst[INST_W-OP_W-2*REG_W-1 -: REG_W]);
        d_src = I_inst[IMM_SRC_W-1:0];
        d_imm = IMM_W'(d_src);
        if ((SIGN_EXT != 0) && d_src[IMM_SRC_W-1]) begin
            d_imm = d_imm | EXT_MASK;
        end
        // Masks are indexed by the opcode without its LSB (pairs of opcodes).
        d_ill   = ILL_MASK[d_op[OP_W-1:1]];
        d_we    = ~(NOWB_MASK[d_op[OP_W-1:1]] | d_ill);
        dec_ent = {d_op, d_a, d_b, d_d, d_imm, d_we, d_ill};
    end

    // room_q is the registered "not FULL" view; it is 0 while in reset so
    // o_ready only rises after the first clock edge out of reset.
    assign o_ready = I_en & room_q;
    assign o_valid = (state_q != EMPTY);
    assign in_x    = I_valid & o_ready;
    assign out_x   = o_valid & I_ready & I_en;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        if (I_en) begin
            if (I_flush) begin
                state_d = EMPTY;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (in_x) begin
                            load_out = 1'b1;
                            state_d  = ONE;
                        end
                    end
                    ONE: begin
                        if (in_x && out_x) begin
                            load_out = 1'b1;
                        end else if (in_x) begin
                            load_skid = 1'b1;
                            state_d   = FULL;
                        end else if (out_x) begin
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_x) begin
                            out_from_skid = 1'b1;
                            state_d       = ONE;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            room_q <= 1'b0;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            room_q <= (state_d != FULL);
            if (load_out) begin
                out_q <= dec_ent;
            end else if (out_from_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec_ent;
            end
        end
    end

    assign {o_aluop, o_selA, o_selB, o_selD, o_imm, o_regwe, o_illegal} = out_q;

endmodule

// File: tb/tb_inst_dec_pipe.sv
// tb/tb_inst_dec_pipe.sv - self-checking bench for inst_dec_pipe
module tb_inst_dec_pipe;

    logic        clk, rst, en, flush, valid, ready;
    logic [15:0] inst;
    logic        o_ready, o_valid, o_regwe, o_illegal;
    logic [4:0]  o_aluop;
    logic [3:0]  o_selA, o_selB, o_selD;
    logic [15:0] o_imm;
    logic        v_ready, v_valid, v_regwe, v_illegal;
    logic [4:0]  v_aluop;
    logic [3:0]  v_selA, v_selB, v_selD;
    logic [15:0] v_imm;

    int errors = 0;
    int checks = 0;

    inst_dec_pipe u_dut (
        .I_clk(clk), .I_rst(rst), .I_en(en), .I_flush(flush),
        .I_inst(inst), .I_valid(valid), .o_ready(o_ready), .o_valid(o_valid),
        .I_ready(ready), .o_aluop(o_aluop), .o_selA(o_selA), .o_selB(o_selB),
        .o_selD(o_selD), .o_imm(o_imm), .o_regwe(o_regwe), .o_illegal(o_illegal)
    );

    inst_dec_pipe #(.SIGN_EXT(0), .ILL_MASK(16'h8000)) u_var (
        .I_clk(clk), .I_rst(rst), .I_en(en), .I_flush(flush),
        .I_inst(inst), .I_valid(valid), .o_ready(v_ready), .o_valid(v_valid),
        .I_ready(ready), .o_aluop(v_aluop), .o_selA(v_selA), .o_selB(v_selB),
        .o_selD(v_selD), .o_imm(v_imm), .o_regwe(v_regwe), .o_illegal(v_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] inst;
        logic [4:0]  op;
        logic [3:0]  a, b, d;
        logic [15:0] imm;
        logic        we, ill;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] dut_tuple();
        return {o_aluop, o_selA, o_selB, o_selD, o_imm, o_regwe, o_illegal};
    endfunction

    // Reference decode for the default parameter set.
    function automatic logic [34:0] model(input logic [15:0] x);
        logic [15:0] nowb;
        logic        we;
        nowb = 16'h3080;
        we   = ~nowb[x[15:12]];
        return {x[15:11], 1'b0, x[10:8], 1'b0, x[7:5], 1'b0, x[4:2],
                {8{x[7]}}, x[7:0], we, 1'b0};
    endfunction

    logic [15:0] q[$];
    int sent, cycles;

    initial begin
        vt[0] = '{16'h3A94, 5'h07, 4'h2, 4'h4, 4'h5, 16'hFF94, 1'b1, 1'b0};
        vt[1] = '{16'h7005, 5'h0E, 4'h0, 4'h0, 4'h1, 16'h0005, 1'b0, 1'b0};
        vt[2] = '{16'hC0FF, 5'h18, 4'h0, 4'h7, 4'h7, 16'hFFFF, 1'b0, 1'b0};
        vt[3] = '{16'hD012, 5'h1A, 4'h0, 4'h0, 4'h4, 16'h0012, 1'b0, 1'b0};
        vt[4] = '{16'h1111, 5'h02, 4'h1, 4'h0, 4'h4, 16'h0011, 1'b1, 1'b0};
        vt[5] = '{16'hF880, 5'h1F, 4'h0, 4'h4, 4'h0, 16'hFF80, 1'b1, 1'b0};
        vt[6] = '{16'h0000, 5'h00, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1; en = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b0; inst = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid", o_valid, 0);
        chk("reset_ready", o_ready, 0);
        chk("reset_outputs", dut_tuple(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", o_ready, 1);
        chk("valid_after_reset", o_valid, 0);

        // Back-to-back decode, one per cycle with I_ready=1.
        for (int i = 0; i < 7; i++) begin
            inst = vt[i].inst; valid = 1'b1; ready = 1'b1;
            @(negedge clk);
            chk($sformatf("dec_%h", vt[i].inst), dut_tuple(),
                {vt[i].op, vt[i].a, vt[i].b, vt[i].d, vt[i].imm, vt[i].we, vt[i].ill});
            chk($sformatf("valid_%0d", i), o_valid, 1);
            chk($sformatf("thru_ready_%0d", i), o_ready, 1);
            if (vt[i].inst == 16'hF880) begin
                chk("variant_F880", {v_valid, v_ready, v_aluop, v_selA, v_selB, v_selD,
                                     v_imm, v_regwe, v_illegal},
                    {1'b1, 1'b1, 5'h1F, 4'h0, 4'h4, 4'h0, 16'h0080, 1'b0, 1'b1});
            end
        end
        valid = 1'b0;
        @(negedge clk);
        chk("drain_valid", o_valid, 0);

        // Back-pressure: fill to FULL, hold, then release.
        ready = 1'b0; inst = 16'h1111; valid = 1'b1;
        @(negedge clk);
        chk("bp_one_imm", o_imm, 16'h0011);
        chk("bp_one_ready", o_ready, 1);
        inst = 16'h2222;
        @(negedge clk);
        chk("bp_full_ready", o_ready, 0);
        chk("bp_full_imm", o_imm, 16'h0011);
        valid = 1'b0; inst = 16'h3333;
        @(negedge clk);
        chk("bp_hold_imm", o_imm, 16'h0011);
        chk("bp_hold_ready", o_ready, 0);
        ready = 1'b1;
        @(negedge clk);
        chk("bp_skid_imm", o_imm, 16'h0022);
        chk("bp_skid_valid", o_valid, 1);
        chk("bp_skid_ready", o_ready, 1);
        @(negedge clk);
        chk("bp_empty_valid", o_valid, 0);

        // Flush while FULL discards both entries and a same-cycle input.
        ready = 1'b0; inst = 16'h4444; valid = 1'b1;
        @(negedge clk);
        inst = 16'h5555;
        @(negedge clk);
        chk("fl_full_ready", o_ready, 0);
        flush = 1'b1; inst = 16'h6666; ready = 1'b1;
        @(negedge clk);
        chk("fl_valid", o_valid, 0);
        chk("fl_ready", o_ready, 1);
        flush = 1'b0; valid = 1'b0;
        @(negedge clk);
        chk("fl_stays_empty", o_valid, 0);

        // Enable low freezes everything.
        ready = 1'b0; inst = 16'h1111; valid = 1'b1;
        @(negedge clk);
        en = 1'b0; inst = 16'h2222; ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("en0_ready_%0d", i), o_ready, 0);
            chk($sformatf("en0_hold_%0d", i), {o_valid, o_imm}, {1'b1, 16'h0011});
        end
        en = 1'b1; valid = 1'b0;
        @(negedge clk);
        chk("en1_drain", o_valid, 0);

        // Asynchronous reset in the middle of operation.
        ready = 1'b0; inst = 16'h1111; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("ar_before", o_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", o_valid, 0);
        chk("ar_imm", o_imm, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Random streaming against an in-order scoreboard.
        sent = 0; cycles = 0;
        while ((sent < 100 || q.size() != 0) && cycles < 3000) begin
            valid = (sent < 100) && ($urandom_range(0, 3) != 0);
            inst  = 16'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_valid", o_valid, q.size() != 0);
            chk("rnd_ready", o_ready, q.size() < 2);
            if (o_valid && ready && q.size() != 0) begin
                chk("rnd_data", dut_tuple(), model(q[0]));
                void'(q.pop_front());
            end
            if (valid && o_ready) begin
                q.push_back(inst);
                sent++;
            end
            @(negedge clk);
            cycles++;
        end
        chk("rnd_complete", {sent, q.size()}, {32'd100, 32'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
